// File: rtl/multi_precision_add_sequencer.sv
// -----------------------------------------------------------------------------
// multi_precision_add_sequencer
//
// Adds two WORDS*N-bit operands by streaming them, least-significant word
// first, through a single N-bit carry-lookahead adder. The carry out of each
// word is registered and fed back as the carry into the next word.
//
// Parameters
//   N      adder width / word size in bits (>= 1)
//   WORDS  number of N-bit words per operand (>= 1)
//   MODEL  internal adder flavour: "Behavioral", "DataFlow" or "Structural"
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand request           in_ready   operands can be accepted
//   a, b, ci   operands + carry-in, sampled on accept
//   out_valid  result available          out_ready  downstream takes result
//   c, co      sum and carry out of the top word, held while out_valid
//   ovf        signed overflow of the full-width add (MPADD_OVERFLOW_EN only)
//   busy       high while adding or holding a result
//
// Optional feature: define MPADD_OVERFLOW_EN to add the ovf output.
// -----------------------------------------------------------------------------

// Prefix combine cell built from gate primitives: g = gh | (ph & gl).
module mpadd_gcell (
   input  logic gh_i,
   input  logic ph_i,
   input  logic gl_i,
   output logic g_o
);
   wire t;
   and u_and (t, ph_i, gl_i);
   or  u_or  (g_o, gh_i, t);
endmodule

// N-bit carry-lookahead adder. DataFlow and Structural both use a
// Kogge-Stone style prefix over generate bits; the group propagate of the
// upper span is a plain AND-reduction of the per-bit propagates, so no
// propagate tree has to be carried between levels.
module mpadd_cla #(
   parameter int N     = 32,
   parameter     MODEL = "Behavioral"
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         ci_i,
   output logic [N-1:0] s_o,
   output logic         co_o
);
   localparam int L = (N > 1) ? $clog2(N) : 0;

   generate
      if (MODEL == "Behavioral") begin : g_beh
         assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, ci_i};

      end else if (MODEL == "DataFlow") begin : g_df
         wire [N-1:0] p = a_i ^ b_i;
         wire [N-1:0] g = a_i & b_i;
         wire [N-1:0] gk [0:L];   // gk[l][i]: carry out of bit i over a 2^l span
         wire [N-1:0] cin;

         // Carry-in is folded into bit 0 so the prefix yields true carries.
         for (genvar i = 0; i < N; i++) begin : g_l0
            if (i == 0) begin : g_b0
               assign gk[0][0] = g[0] | (p[0] & ci_i);
               assign cin[0]   = ci_i;
            end else begin : g_bn
               assign gk[0][i] = g[i];
               assign cin[i]   = gk[L][i-1];
            end
         end
         for (genvar l = 1; l <= L; l++) begin : g_lvl
            localparam int D = 1 << (l - 1);
            for (genvar i = 0; i < N; i++) begin : g_bit
               if (i >= D) begin : g_mix
                  assign gk[l][i] = gk[l-1][i] | ((&p[i -: D]) & gk[l-1][i-D]);
               end else begin : g_cpy
                  assign gk[l][i] = gk[l-1][i];
               end
            end
         end
         assign s_o  = p ^ cin;
         assign co_o = gk[L][N-1];

      end else if (MODEL == "Structural") begin : g_st
         wire [N-1:0] p;
         wire [N-1:0] g;
         wire [N-1:0] s;
         wire [N-1:0] gk [0:L];
         wire [N-1:0] cin;

         for (genvar i = 0; i < N; i++) begin : g_pg
            xor u_p (p[i], a_i[i], b_i[i]);
            and u_g (g[i], a_i[i], b_i[i]);
            if (i == 0) begin : g_b0
               mpadd_gcell u_c0 (.gh_i(g[0]), .ph_i(p[0]), .gl_i(ci_i), .g_o(gk[0][0]));
               assign cin[0] = ci_i;
            end else begin : g_bn
               assign gk[0][i] = g[i];
               assign cin[i]   = gk[L][i-1];
            end
            xor u_s (s[i], p[i], cin[i]);
         end
         for (genvar l = 1; l <= L; l++) begin : g_lvl
            localparam int D = 1 << (l - 1);
            for (genvar i = 0; i < N; i++) begin : g_bit
               if (i >= D) begin : g_mix
                  wire ph = &p[i -: D];
                  mpadd_gcell u_cell (.gh_i(gk[l-1][i]), .ph_i(ph),
                                      .gl_i(gk[l-1][i-D]), .g_o(gk[l][i]));
               end else begin : g_cpy
                  assign gk[l][i] = gk[l-1][i];
               end
            end
         end
         assign s_o  = s;
         assign co_o = gk[L][N-1];

      end else begin : g_bad
         $error("mpadd_cla: unsupported MODEL value");
      end
   endgenerate
endmodule

module multi_precision_add_sequencer #(
   parameter int N     = 32,
   parameter int WORDS = 4,
   parameter     MODEL = "Behavioral"
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   a,
   input  logic [N*WORDS-1:0]   b,
   input  logic                 ci,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   c,
   output logic                 co,
`ifdef MPADD_OVERFLOW_EN
   output logic                 ovf,
`endif
   output logic                 busy
);
   localparam int            KW   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] LAST = KW'(WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

   state_t                      state_q;
   logic [KW-1:0]               k_q, k_d;
   logic [WORDS-1:0][N-1:0]     a_q, b_q, res_q;
   logic                        carry_q, co_q;
   logic                        out_valid_q, busy_q, in_ready_q;
   logic [N-1:0]                a_w, b_w, sum_w;
   logic                        add_co;

   // Word k of the captured operands feeds the shared adder.
   assign a_w = a_q[k_q];
   assign b_w = b_q[k_q];
   assign k_d = k_q + 1'b1;

   mpadd_cla #(.N(N), .MODEL(MODEL)) u_add (
      .a_i (a_w),
      .b_i (b_w),
      .ci_i(carry_q),
      .s_o (sum_w),
      .co_o(add_co)
   );

`ifdef MPADD_OVERFLOW_EN
   logic ovf_q;
   logic msb_cin;
   // Carry into the MSB recovered from the MSB sum bit and its operands.
   assign msb_cin = sum_w[N-1] ^ a_w[N-1] ^ b_w[N-1];
   assign ovf     = ovf_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         co_q        <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
`ifdef MPADD_OVERFLOW_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  carry_q    <= ci;
                  k_q        <= '0;
                  res_q      <= '0;
                  state_q    <= S_ADD;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_ADD: begin
               res_q[k_q] <= sum_w;
               carry_q    <= add_co;
               k_q        <= k_d;
               if (k_q == LAST) begin
                  state_q     <= S_DONE;
                  co_q        <= add_co;
                  out_valid_q <= 1'b1;
`ifdef MPADD_OVERFLOW_EN
                  ovf_q       <= msb_cin ^ add_co;
`endif
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // in_ready must read low during reset even though its register resets high.
   assign in_ready  = in_ready_q & ~rst;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign c         = res_q;
   assign co        = co_q;
endmodule

// File: tb/tb_multi_precision_add_sequencer.sv
module tb_multi_precision_add_sequencer;
   localparam int W  = 4;
   localparam int NW = 128;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, in_valid, in_ready, ci, out_valid, out_ready, co, busy;
   logic [NW-1:0] a, b, c;
`ifdef MPADD_OVERFLOW_EN
   logic          ovf;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   multi_precision_add_sequencer #(.N(32), .WORDS(W), .MODEL("Behavioral")) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
      .c(c), .co(co),
`ifdef MPADD_OVERFLOW_EN
      .ovf(ovf),
`endif
      .busy(busy));

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Present operands and hold in_valid until an accepting edge; returns #1 after it.
   task automatic start_op(input logic [NW-1:0] ta, input logic [NW-1:0] tb_, input logic tci);
      bit acc = 0;
      @(negedge clk);
      a = ta; b = tb_; ci = tci; in_valid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         if (t > 0) @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         if (acc) break;
      end
      #1;
      in_valid = 1'b0; a = ~ta; b = ~tb_; ci = ~tci;  // later changes must not matter
      check("accept", 160'(acc), 160'(1));
   endtask

   // Count whole cycles until out_valid is seen at a falling edge.
   task automatic wait_result(output int lat, output int busyc);
      bit seen = 0;
      lat = 0; busyc = 0;
      for (int t = 0; t < 40 && !seen; t++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
         else begin
            lat++;
            if (busy) busyc++;
         end
      end
      check("result_seen", 160'(seen), 160'(1));
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   typedef struct {
      logic [NW-1:0] a, b;
      logic          ci;
      logic [NW-1:0] c;
      logic          co, ovf;
   } vec_t;

   // ---------------------------------------------------------------------------
   // Randomised regression over every MODEL and three N/WORDS shapes.
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < 9; g++) begin : g_rnd
      localparam int GN = (g % 3 == 2) ? 32 : 8;
      localparam int GW = (g % 3 == 0) ? 1 : (g % 3 == 1) ? 5 : 4;
      localparam int GB = GN * GW;
      localparam     GM = (g < 3) ? "Behavioral" : (g < 6) ? "DataFlow" : "Structural";

      logic          rrst, rin_valid, rin_ready, rci, rout_valid, rout_ready, rco, rbusy;
      logic [GB-1:0] ra, rb, rc;
`ifdef MPADD_OVERFLOW_EN
      logic          rovf;
`endif

      multi_precision_add_sequencer #(.N(GN), .WORDS(GW), .MODEL(GM)) u_dut (
         .clk(clk), .rst(rrst), .in_valid(rin_valid), .in_ready(rin_ready),
         .a(ra), .b(rb), .ci(rci), .out_valid(rout_valid), .out_ready(rout_ready),
         .c(rc), .co(rco),
`ifdef MPADD_OVERFLOW_EN
         .ovf(rovf),
`endif
         .busy(rbusy));

      initial begin
         logic [GB:0] exp_v, sx;
         logic        exp_ovf;
         bit          acc, hs;
         int          mode;
         rrst = 1'b1; rin_valid = 1'b0; rout_ready = 1'b0; ra = '0; rb = '0; rci = 1'b0;
         repeat (2) @(posedge clk);
         @(negedge clk) rrst = 1'b0;
         for (int op = 0; op < 1000; op++) begin
            @(negedge clk);
            mode = $urandom_range(0, 9);
            for (int i = 0; i < GB; i++) begin
               ra[i] = 1'($urandom_range(0, 1));
               rb[i] = 1'($urandom_range(0, 1));
            end
            if (mode == 0) ra = '1;
            if (mode == 1) begin ra = '1; rb = '1; end
            if (mode == 2) begin ra = '0; ra[GB-1] = 1'b1; rb = '1; end
            if (mode == 3) begin ra = '1; ra[GB-1] = 1'b0; rb = '0; end
            rci = 1'($urandom_range(0, 1));
            // Reference: plain wide arithmetic, and overflow from the
            // sign-extended exact sum not fitting in GB bits.
            exp_v   = ra + rb + rci;
            sx      = {ra[GB-1], ra} + {rb[GB-1], rb} + rci;
            exp_ovf = sx[GB] ^ sx[GB-1];
            rin_valid = 1'b1;
            acc = 0;
            for (int t = 0; t < 20; t++) begin
               if (t > 0) @(negedge clk);
               acc = rin_ready;
               @(posedge clk);
               if (acc) break;
            end
            #1;
            rin_valid = 1'b0; ra = ~ra; rb = ~rb; rci = ~rci;
            if (!acc) check($sformatf("rnd%0d_accept", g), 160'(acc), 160'(1));
            hs = 0;
            for (int t = 0; t < 200 && !hs; t++) begin
               @(negedge clk);
               rout_ready = ($urandom_range(0, 2) != 0);
               check($sformatf("rnd%0d_rdy_vld_excl", g), 160'(rin_ready & rout_valid), 160'(0));
               if (rout_valid) begin
                  check($sformatf("rnd%0d_sum op%0d", g, op), 160'({rco, rc}), 160'(exp_v));
`ifdef MPADD_OVERFLOW_EN
                  check($sformatf("rnd%0d_ovf op%0d", g, op), 160'(rovf), 160'(exp_ovf));
`endif
               end
               hs = rout_valid && rout_ready;
               @(posedge clk);
            end
            if (!hs) check($sformatf("rnd%0d_handshake", g), 160'(hs), 160'(1));
         end
         done_cnt++;
      end
   end

   // ---------------------------------------------------------------------------
   // Directed tests on the default configuration.
   // ---------------------------------------------------------------------------
   initial begin
      vec_t          vt[8];
      int            lat, busyc;
      logic [NW-1:0] c0;
      logic          co0;

      vt[0] = '{'1, 128'd1, 1'b0, 128'd0, 1'b1, 1'b0};
      vt[1] = '{128'h00000000_00000000_00000000_FFFFFFFF, 128'd0, 1'b1,
                128'h00000000_00000000_00000001_00000000, 1'b0, 1'b0};
      vt[2] = '{128'd5, 128'd7, 1'b0, 128'd12, 1'b0, 1'b0};
      vt[3] = '{{1'b0, {127{1'b1}}}, 128'd1, 1'b0, {1'b1, 127'd0}, 1'b0, 1'b1};
      vt[4] = '{{1'b1, 127'd0}, '1, 1'b0, {1'b0, {127{1'b1}}}, 1'b1, 1'b1};
      vt[5] = '{128'd5, 128'd3, 1'b0, 128'd8, 1'b0, 1'b0};
      vt[6] = '{'1, '1, 1'b1, '1, 1'b1, 1'b0};
      vt[7] = '{128'h00000001_80000000_FFFFFFFF_00000000,
                128'h00000001_80000000_00000001_00000000, 1'b0,
                128'h00000003_00000001_00000000_00000000, 1'b0, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", 160'({in_ready, out_valid, busy, co, c}), 160'(0));
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 160'({in_ready, busy}), 160'(2'b10));

      for (int i = 0; i < 8; i++) begin
         out_ready = 1'b0;
         start_op(vt[i].a, vt[i].b, vt[i].ci);
         wait_result(lat, busyc);
         check($sformatf("vec%0d_c", i), 160'(c), 160'(vt[i].c));
         check($sformatf("vec%0d_co", i), 160'(co), 160'(vt[i].co));
`ifdef MPADD_OVERFLOW_EN
         check($sformatf("vec%0d_ovf", i), 160'(ovf), 160'(vt[i].ovf));
`endif
         check($sformatf("vec%0d_latency", i), 160'(lat), 160'(W));
         check($sformatf("vec%0d_busy_add", i), 160'(busyc), 160'(W));
         check($sformatf("vec%0d_done_flags", i), 160'({busy, in_ready}), 160'(2'b10));
         release_result();
         @(negedge clk);
         check($sformatf("vec%0d_idle_flags", i), 160'({out_valid, busy, in_ready}), 160'(3'b001));
      end

      // Backpressure: result held for 10 cycles while new operands wait.
      out_ready = 1'b0;
      start_op(128'h1234, 128'h1111, 1'b1);
      wait_result(lat, busyc);
      c0 = c; co0 = co;
      check("bp_first", 160'({co0, c0}), 160'(129'h2346));
      a = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF; b = 128'h11; ci = 1'b0; in_valid = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         check("bp_hold", 160'({out_valid, in_ready, co, c}), 160'({1'b1, 1'b0, co0, c0}));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release", 160'({out_valid, in_ready}), 160'(2'b01));
      @(posedge clk);
      #1 in_valid = 1'b0; a = '0; b = '0;
      wait_result(lat, busyc);
      check("bp_second", 160'({co, c}), 160'(129'hDEAD_0000_0000_0000_0000_0000_0000_BF00));
      check("bp_second_latency", 160'(lat), 160'(W));
      release_result();

      // Reset while the word counter sits at word 2.
      start_op('1, 128'd1, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_ready_low", 160'(in_ready), 160'(0));
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_add", 160'({in_ready, out_valid, busy, co, c}), 160'({1'b1, 131'd0}));
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         check("rst_no_pulse", 160'(out_valid), 160'(0));
      end
      start_op(128'd5, 128'd7, 1'b0);
      wait_result(lat, busyc);
      check("rst_next_op", 160'({co, c}), 160'(12));
      release_result();

      // Reset and in_valid together: nothing is captured.
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b1; a = 128'd9; b = 128'd9;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("rst_wins", 160'({busy, in_ready, out_valid}), 160'(3'b010));

      for (int t = 0; t < 60000 && done_cnt < 9; t++) @(posedge clk);
      check("rnd_done", 160'(done_cnt), 160'(9));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
